// File: rtl/control_unit_pkg.sv
// Shared definitions for the microprogram control unit.
//   nsa_sel_e     : next-state address source select (2-bit)
//   NSC_*         : next-state control codes from the microinstruction (3-bit)
//   seq_state_e   : sequencer FSM state encoding
//   decode_select : maps NSC + condition to an address source
package control_unit_pkg;

  typedef enum logic [1:0] {
    SEL_ENCODER = 2'b00,
    SEL_FETCH   = 2'b01,
    SEL_CR      = 2'b10,
    SEL_INCR    = 2'b11
  } nsa_sel_e;

  localparam logic [2:0] NSC_ENCODER     = 3'b000;
  localparam logic [2:0] NSC_FETCH       = 3'b001;
  localparam logic [2:0] NSC_CR          = 3'b010;
  localparam logic [2:0] NSC_INCR        = 3'b011;
  localparam logic [2:0] NSC_BR_ENCODER  = 3'b100;
  localparam logic [2:0] NSC_BR_FETCH    = 3'b101;
  localparam logic [2:0] NSC_BR_INCR     = 3'b110;
  localparam logic [2:0] NSC_BR_INCR_ALT = 3'b111;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_WAIT_MOC = 2'b01,
    ST_FAULT    = 2'b10
  } seq_state_e;

  // Unconditional codes pass their low bits straight through; conditional
  // codes fall back to the control register when the condition is false.
  function automatic nsa_sel_e decode_select(input logic [2:0] nsc, input logic cond);
    nsa_sel_e sel;
    if (!nsc[2]) begin
      sel = nsa_sel_e'(nsc[1:0]);
    end else if (!cond) begin
      sel = SEL_CR;
    end else begin
      case (nsc)
        NSC_BR_ENCODER: sel = SEL_ENCODER;
        NSC_BR_FETCH:   sel = SEL_FETCH;
        default:        sel = SEL_INCR;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/moc_watchdog.sv
// Wait-cycle counter for memory-operation-complete handshakes.
// Ports:
//   Clock    in  system clock
//   Reset    in  synchronous active-high reset
//   start    in  load count = 1 (first wait cycle)
//   count_en in  advance count by one
//   clear    in  return count to 0 (highest priority)
//   expired  out count has reached TIMEOUT-1
module moc_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic Clock,
  input  logic Reset,
  input  logic start,
  input  logic count_en,
  input  logic clear,
  output logic expired
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (start) begin
      cnt_d = 8'd1;
    end else if (count_en) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/microprogram_sequencer.sv
// Microprogram sequencer: selects and registers the next microstore address,
// stalls on memory operations and traps when MOC never arrives.
// Ports:
//   Clock, Reset                 system clock, synchronous active-high reset
//   Hold                         freeze all state
//   Next_State_Control [2:0]     next-state mode of current microinstruction
//   Encoder_Address, Control_Register_Address  candidate targets
//   Cond, MOC, Cond_Select, Invert             branch condition inputs
//   Error_Clear                  clears the sticky bus error
//   State_Address                current microstate (registered)
//   Next_State_Address_Select    combinational source select
//   Waiting_MOC                  high while stalled on MOC
//   Bus_Error                    sticky MOC-timeout flag
//
// state       | meaning
// ST_RUN      | normal sequencing
// ST_WAIT_MOC | stalled on a memory operation, watchdog counting
// ST_FAULT    | MOC timed out, State_Address holds the trap vector
module microprogram_sequencer
  import control_unit_pkg::*;
#(
  parameter int ADDR_WIDTH    = 8,
  parameter int FETCH_ADDRESS = 1,
  parameter int TRAP_ADDRESS  = 255,
  parameter int MOC_TIMEOUT   = 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Hold,
  input  logic [2:0]            Next_State_Control,
  input  logic [ADDR_WIDTH-1:0] Encoder_Address,
  input  logic [ADDR_WIDTH-1:0] Control_Register_Address,
  input  logic                  Cond,
  input  logic                  MOC,
  input  logic                  Cond_Select,
  input  logic                  Invert,
  input  logic                  Error_Clear,
  output logic [ADDR_WIDTH-1:0] State_Address,
  output logic [1:0]            Next_State_Address_Select,
  output logic                  Waiting_MOC,
  output logic                  Bus_Error
);

  logic                  cond_ctl;
  nsa_sel_e              sel;
  seq_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  err_q, err_d;
  logic                  wd_start, wd_en, wd_clear, wd_expired;

  assign cond_ctl = (Cond_Select ? MOC : Cond) ^ Invert;
  assign sel      = decode_select(Next_State_Control, cond_ctl);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    err_d    = err_q;
    wd_start = 1'b0;
    wd_en    = 1'b0;
    wd_clear = 1'b0;
    if (!Hold) begin
      case (sel)
        SEL_ENCODER: addr_d = Encoder_Address;
        SEL_FETCH:   addr_d = ADDR_WIDTH'(FETCH_ADDRESS);
        SEL_CR:      addr_d = Control_Register_Address;
        default:     addr_d = addr_q + ADDR_WIDTH'(1);
      endcase
      if (Error_Clear) err_d = 1'b0;
      case (state_q)
        ST_RUN: begin
          if (Next_State_Control[2] && Cond_Select && !cond_ctl) begin
            state_d  = ST_WAIT_MOC;
            wd_start = 1'b1;
          end
        end
        ST_WAIT_MOC: begin
          // A true condition wins even on the timeout cycle.
          if (cond_ctl) begin
            state_d  = ST_RUN;
            wd_clear = 1'b1;
          end else if (wd_expired) begin
            state_d  = ST_FAULT;
            addr_d   = ADDR_WIDTH'(TRAP_ADDRESS);
            err_d    = 1'b1;  // set beats a simultaneous clear
            wd_clear = 1'b1;
          end else begin
            wd_en = 1'b1;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_RUN;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  moc_watchdog #(
    .TIMEOUT(MOC_TIMEOUT)
  ) u_watchdog (
    .Clock   (Clock),
    .Reset   (Reset),
    .start   (wd_start),
    .count_en(wd_en),
    .clear   (wd_clear),
    .expired (wd_expired)
  );

  assign State_Address             = addr_q;
  assign Next_State_Address_Select = sel;
  assign Waiting_MOC               = (state_q == ST_WAIT_MOC);
  assign Bus_Error                 = err_q;

endmodule

// File: tb/tb_microprogram_sequencer.sv
module tb_microprogram_sequencer;

  localparam int AW      = 8;
  localparam int FETCH   = 1;
  localparam int TRAP    = 255;
  localparam int TIMEOUT = 16;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          Hold = 1'b0;
  logic [2:0]    nsc = 3'd0;
  logic [AW-1:0] enc = '0;
  logic [AW-1:0] cr = '0;
  logic          cond = 1'b0, moc = 1'b0, cs = 1'b0, inv = 1'b0, clr = 1'b0;
  logic [AW-1:0] sa;
  logic [1:0]    sel;
  logic          wm, be;

  int vectors = 0;
  int miscompares = 0;

  // reference model: abstract sequencer status
  int m_addr = 0;
  int m_wait_cycles = 0;  // 0 = not waiting, else cycles spent waiting so far
  bit m_in_trap = 0;
  bit m_err = 0;

  microprogram_sequencer #(
    .ADDR_WIDTH(AW), .FETCH_ADDRESS(FETCH), .TRAP_ADDRESS(TRAP), .MOC_TIMEOUT(TIMEOUT)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Hold(Hold), .Next_State_Control(nsc),
    .Encoder_Address(enc), .Control_Register_Address(cr),
    .Cond(cond), .MOC(moc), .Cond_Select(cs), .Invert(inv), .Error_Clear(clr),
    .State_Address(sa), .Next_State_Address_Select(sel),
    .Waiting_MOC(wm), .Bus_Error(be)
  );

  always #5 Clock = ~Clock;

  function automatic bit model_cond();
    return ((cs ? moc : cond) ^ inv) != 0;
  endfunction

  // Table: 0..3 direct; 4..7 false -> 2; true: 4->0, 5->1, 6/7->3
  function automatic int model_sel();
    int n = int'(nsc);
    if (n < 4) return n;
    if (!model_cond()) return 2;
    if (n == 4) return 0;
    if (n == 5) return 1;
    return 3;
  endfunction

  task automatic model_edge();
    int target;
    bit c;
    if (Reset) begin
      m_addr = 0; m_wait_cycles = 0; m_in_trap = 0; m_err = 0;
      return;
    end
    if (Hold) return;
    c = model_cond();
    case (model_sel())
      0: target = int'(enc);
      1: target = FETCH;
      2: target = int'(cr);
      default: target = (m_addr + 1) % (1 << AW);
    endcase
    if (clr) m_err = 0;
    if (m_wait_cycles > 0) begin
      if (c) m_wait_cycles = 0;
      else if (m_wait_cycles < TIMEOUT - 1) m_wait_cycles++;
      else begin
        m_wait_cycles = 0; m_in_trap = 1; m_err = 1; target = TRAP;
      end
    end else if (m_in_trap) begin
      m_in_trap = 0;
    end else if (nsc[2] && cs && !c) begin
      m_wait_cycles = 1;
    end
    m_addr = target;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check combinational select, take the edge, check state.
  task automatic tick();
    #1;
    chk("select", 32'(sel), 32'(model_sel()));
    @(posedge Clock);
    model_edge();
    #1;
    chk("state_address", 32'(sa), 32'(m_addr));
    chk("waiting_moc", 32'(wm), 32'(m_wait_cycles > 0));
    chk("bus_error", 32'(be), 32'(m_err));
  endtask

  task automatic set_in(input logic [2:0] n, input logic [AW-1:0] c_r, input logic s, input logic m);
    nsc = n; cr = c_r; cs = s; moc = m;
  endtask

  initial begin
    // reset
    Reset = 1; tick(); tick();
    chk("reset_addr", 32'(sa), 32'd0);
    chk("reset_wait", 32'(wm), 32'd0);
    Reset = 0;

    // incrementer 0,1,2,3
    set_in(3'b011, 8'h00, 0, 0);
    repeat (3) tick();
    chk("incr3", 32'(sa), 32'd3);

    // wrap 255 -> 0
    set_in(3'b010, 8'hFF, 0, 0); tick();
    set_in(3'b011, 8'hFF, 0, 0); tick();
    chk("wrap", 32'(sa), 32'd0);

    // MOC wait then complete
    set_in(3'b111, 8'h20, 1, 0); inv = 0;
    repeat (3) begin
      tick();
      chk("wait_addr", 32'(sa), 32'h20);
      chk("wait_flag", 32'(wm), 32'd1);
    end
    moc = 1; tick();
    chk("moc_done", 32'(sa), 32'h21);
    chk("moc_done_wait", 32'(wm), 32'd0);

    // timeout: 16 cycles to trap
    set_in(3'b111, 8'h20, 1, 0);
    repeat (16) tick();
    chk("trap_addr", 32'(sa), 32'd255);
    chk("trap_err", 32'(be), 32'd1);
    set_in(3'b011, 8'h20, 0, 0); clr = 1; tick(); clr = 0;
    chk("err_cleared", 32'(be), 32'd0);
    chk("trap_next", 32'(sa), 32'd0);

    // fault coincident with clear keeps the error
    set_in(3'b111, 8'h20, 1, 0); clr = 1;
    repeat (16) tick();
    chk("fault_vs_clear", 32'(be), 32'd1);
    set_in(3'b011, 8'h20, 0, 0); tick(); tick(); clr = 0;

    // MOC on the timeout cycle: no fault
    set_in(3'b111, 8'h20, 1, 0);
    repeat (15) tick();
    moc = 1; tick();
    chk("moc_at_timeout_err", 32'(be), 32'd0);
    chk("moc_at_timeout_addr", 32'(sa), 32'h21);

    // invert and encoder select
    enc = 8'h5A; set_in(3'b100, 8'h33, 0, 0); cond = 1; inv = 1;
    #1 chk("inv_sel", 32'(sel), 32'd2);
    tick();
    chk("inv_cr", 32'(sa), 32'h33);
    inv = 0; tick();
    chk("enc_load", 32'(sa), 32'h5A);
    cond = 0;

    // switch to Cond during wait exits
    set_in(3'b111, 8'h20, 1, 0); tick();
    cs = 0; cond = 1; tick();
    chk("cs_switch_exit", 32'(wm), 32'd0);
    chk("cs_switch_addr", 32'(sa), 32'h21);
    cond = 0;

    // hold mid-wait
    set_in(3'b111, 8'h20, 1, 0);
    repeat (3) tick();
    Hold = 1; set_in(3'b011, 8'h40, 1, 1); clr = 1;
    repeat (5) tick();
    chk("hold_addr", 32'(sa), 32'h20);
    chk("hold_wait", 32'(wm), 32'd1);
    Hold = 0; clr = 0; set_in(3'b111, 8'h20, 1, 0);
    repeat (12) tick();
    chk("hold_count_kept", 32'(wm), 32'd1);
    tick();
    chk("hold_trap", 32'(sa), 32'd255);

    // reset mid-wait, with hold asserted
    set_in(3'b111, 8'h20, 1, 0);
    repeat (3) tick();
    Reset = 1; Hold = 1; tick();
    chk("reset_wait_addr", 32'(sa), 32'd0);
    chk("reset_wait_flag", 32'(wm), 32'd0);
    Reset = 0; Hold = 0;

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      Reset = ($urandom_range(0, 63) == 0);
      Hold  = ($urandom_range(0, 7) == 0);
      nsc   = 3'($urandom_range(0, 7));
      enc   = 8'($urandom);
      cr    = 8'($urandom);
      cond  = 1'($urandom);
      moc   = ($urandom_range(0, 9) == 0);
      cs    = ($urandom_range(0, 3) != 0);
      inv   = ($urandom_range(0, 5) == 0);
      clr   = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/microprogram_sequencer.md
MICROPROGRAM_SEQUENCER -- requirements
Module: microprogram_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, microstore address width.
REQ-002 SHALL have parameter FETCH_ADDRESS, default 1, microstate that starts instruction fetch.
REQ-003 SHALL have parameter TRAP_ADDRESS, default 255, microstate entered on MOC timeout.
REQ-004 SHALL have parameter MOC_TIMEOUT, default 16, maximum wait cycles for MOC (range 2..255).
REQ-005 SHALL have ports, in order: Clock in 1 system clock; Reset in 1 synchronous, active-high reset.
REQ-006 SHALL have port Hold in 1, which freezes all state when high.
REQ-007 SHALL have port Next_State_Control in 3, next-state mode from the current microinstruction.
REQ-008 SHALL have ports Encoder_Address in ADDR_WIDTH (decoded opcode target) and Control_Register_Address in ADDR_WIDTH (CR field).
REQ-009 SHALL have ports Cond in 1 (branch condition), MOC in 1 (memory operation complete), Cond_Select in 1 (1 = MOC, 0 = Cond) and Invert in 1.
REQ-010 SHALL have port Error_Clear in 1, which clears Bus_Error.
REQ-011 SHALL have outputs State_Address out ADDR_WIDTH (current microstate), Next_State_Address_Select out 2, Waiting_MOC out 1 and Bus_Error out 1.

Function
REQ-012 SHALL compute Condition_Control = (Cond_Select ? MOC : Cond) XOR Invert, combinationally.
REQ-013 SHALL drive select combinationally; codes: 00 encoder, 01 fetch, 10 control register, 11 incrementer.
REQ-014 SHALL decode NSC 000/001/010/011 to select 00/01/10/11 regardless of condition.
REQ-015 SHALL decode NSC 1xx with condition false to select 10; with condition true, 100→00, 101→01, 110→11 and 111→11.
REQ-016 SHALL take the selected source on each non-held clock edge: Encoder_Address, FETCH_ADDRESS, Control_Register_Address or State_Address+1 (modulo 2^ADDR_WIDTH; max wraps to 0).
REQ-017 SHALL sequence with FSM states RUN, WAIT_MOC and FAULT.
REQ-018 SHALL move RUN→WAIT_MOC with wait count 1 when NSC[2]=1, Cond_Select=1 and condition is false; the address is still loaded per REQ-015.
REQ-019 SHALL, in WAIT_MOC with the condition true, return to RUN and clear the count, with the address advancing per REQ-015.
REQ-020 SHALL, in WAIT_MOC with the condition false and count < MOC_TIMEOUT-1, increment the count and follow select as normal.
REQ-021 SHALL, in WAIT_MOC with the condition false and count = MOC_TIMEOUT-1, go to FAULT, load State_Address = TRAP_ADDRESS and set Bus_Error.
REQ-022 SHALL, in FAULT, return to RUN on the next non-held edge, with the address advancing per REQ-015 from TRAP_ADDRESS.
REQ-023 SHALL give MOC precedence when MOC asserts on the timeout cycle: no fault.
REQ-024 SHALL drive Waiting_MOC = 1 exactly when the FSM is in WAIT_MOC.
REQ-025 SHALL keep Bus_Error sticky until Error_Clear; a simultaneous fault and clear leaves Bus_Error = 1.
REQ-026 SHALL, when Hold=1, keep State_Address, FSM, count and Bus_Error unchanged; Error_Clear is ignored while held.
REQ-027 SHALL, in WAIT_MOC, evaluate the condition with whatever Cond_Select is presented; a change to Cond_Select=0 with condition true exits WAIT_MOC.
REQ-028 SHALL register the next address, so State_Address changes one cycle after its inputs are sampled.

Reset
REQ-029 SHALL, on Reset high at a clock edge: State_Address = 0, FSM = RUN, count = 0, Bus_Error = 0, Waiting_MOC = 0.
REQ-030 SHALL give Reset precedence over Hold, MOC, timeout and Error_Clear, including mid-wait.

Structure
REQ-031 SHALL place the select codes (2-bit), NSC codes (3-bit) and FSM state encoding in the shared package control_unit_pkg.
REQ-032 SHALL implement the wait counter plus timeout compare as sub-module moc_watchdog (inputs start, count_en, clear; output expired).

Verification
REQ-033 SHALL cover: Reset, then NSC=011 for 3 cycles → State_Address 0,1,2,3.
REQ-034 SHALL cover: State_Address=255, NSC=011 → State_Address 0.
REQ-035 SHALL cover: NSC=111, Cond_Select=1, Invert=0, CR=0x20, MOC low 3 cycles then high → Waiting_MOC high 3 cycles, address 0x20 while waiting, then 0x21.
REQ-036 SHALL cover: same stimulus as REQ-035 with MOC never rising and MOC_TIMEOUT=16 → after 16 wait cycles State_Address=255, Bus_Error=1; Error_Clear → 0.
REQ-037 SHALL cover: NSC=100, Cond_Select=0, Cond=1, Invert=1 → select 10, loads CR; with Invert=0 → select 00, loads Encoder_Address.
REQ-038 SHALL cover: Hold=1 mid-WAIT_MOC for 5 cycles → address and count frozen; Reset during WAIT_MOC → State_Address 0, Waiting_MOC 0.
